// File: rtl/dataplane_axil_regs_if.sv
// AXI4-Lite bus bundle between the dataplane register bank and its master.
// Signal names follow the AXI4-Lite channel naming so waveforms read naturally.
interface dataplane_axil_regs_if #(
   parameter int unsigned ADDR_W = 8
) ();
   logic [ADDR_W-1:0] AWADDR;
   logic [2:0]        AWPROT;
   logic              AWVALID;
   logic              AWREADY;
   logic [31:0]       WDATA;
   logic [3:0]        WSTRB;
   logic              WVALID;
   logic              WREADY;
   logic              BREADY;
   logic              BVALID;
   logic [1:0]        BRESP;
   logic [ADDR_W-1:0] ARADDR;
   logic [2:0]        ARPROT;
   logic              ARVALID;
   logic              ARREADY;
   logic              RREADY;
   logic              RVALID;
   logic [31:0]       RDATA;
   logic [1:0]        RRESP;

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      output ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      input  ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );
endinterface

// File: rtl/dataplane_axil_regs.sv
// AXI4-Lite slave register bank: read-only VERSION at index 0 and NUM_REGS-1
// byte-writable control registers exported flat to the dataplane datapath.
module dataplane_axil_regs #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned NUM_REGS = 8,
   parameter logic [31:0] VERSION  = 32'h0001_0000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   dataplane_axil_regs_if.slave      axil,
   output logic [32*NUM_REGS-1:0]    regs_o
);

   localparam int unsigned IdxW  = ADDR_W - 2;
   localparam int unsigned NumRw = NUM_REGS - 1;
   localparam logic [1:0]  RespOkay   = 2'b00;
   localparam logic [1:0]  RespSlvErr = 2'b10;

   logic              ready_en_q;

   logic              aw_held_q, aw_held_d;
   logic [IdxW-1:0]   aw_idx_q, aw_idx_d;
   logic              w_held_q, w_held_d;
   logic [31:0]       w_data_q, w_data_d;
   logic [3:0]        w_strb_q, w_strb_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;

   logic              rvalid_q, rvalid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;

   logic [31:0]       rw_q [NumRw];
   logic [31:0]       rw_d [NumRw];

   logic              aw_ready, w_ready, ar_ready;
   logic              aw_hs, w_hs, ar_hs;
   logic              commit;
   logic [IdxW-1:0]   ar_idx;
   logic [31:0]       rd_data_c;
   logic [1:0]        rd_resp_c;

   // Protection bits and byte offsets carry no meaning for a word register bank.
   logic unused_bits;
   assign unused_bits = ^{axil.AWPROT, axil.ARPROT, axil.AWADDR[1:0], axil.ARADDR[1:0]};

   function automatic logic idx_is_rw(logic [IdxW-1:0] idx);
      return (idx != '0) && (32'(idx) < NUM_REGS);
   endfunction

   // Handshakes are blocked while a response is pending: one write and one read in flight.
   assign aw_ready = ready_en_q && !aw_held_q && !bvalid_q;
   assign w_ready  = ready_en_q && !w_held_q && !bvalid_q;
   assign ar_ready = ready_en_q && !rvalid_q;

   assign aw_hs  = axil.AWVALID && aw_ready;
   assign w_hs   = axil.WVALID && w_ready;
   assign ar_hs  = axil.ARVALID && ar_ready;
   assign commit = aw_held_q && w_held_q;
   assign ar_idx = axil.ARADDR[ADDR_W-1:2];

   assign axil.AWREADY = aw_ready;
   assign axil.WREADY  = w_ready;
   assign axil.BVALID  = bvalid_q;
   assign axil.BRESP   = bresp_q;
   assign axil.ARREADY = ar_ready;
   assign axil.RVALID  = rvalid_q;
   assign axil.RDATA   = rdata_q;
   assign axil.RRESP   = rresp_q;

   always_comb begin
      aw_held_d = aw_held_q;
      aw_idx_d  = aw_idx_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rw_d      = rw_q;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = axil.AWADDR[ADDR_W-1:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = axil.WDATA;
         w_strb_d = axil.WSTRB;
      end

      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = idx_is_rw(aw_idx_q) ? RespOkay : RespSlvErr;
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (32'(aw_idx_q) == i) begin
               for (int unsigned b = 0; b < 4; b++) begin
                  if (w_strb_q[b]) begin
                     rw_d[i-1][8*b +: 8] = w_data_q[8*b +: 8];
                  end
               end
            end
         end
      end else if (bvalid_q && axil.BREADY) begin
         bvalid_d = 1'b0;
      end
   end

   // Reads sample the current flops, so a read on a commit edge sees the old value.
   always_comb begin
      rd_data_c = '0;
      rd_resp_c = RespSlvErr;
      if (ar_idx == '0) begin
         rd_data_c = VERSION;
         rd_resp_c = RespOkay;
      end else begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (32'(ar_idx) == i) begin
               rd_data_c = rw_q[i-1];
               rd_resp_c = RespOkay;
            end
         end
      end
   end

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_data_c;
         rresp_d  = rd_resp_c;
      end else if (rvalid_q && axil.RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_comb begin
      regs_o        = '0;
      regs_o[31:0]  = VERSION;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         regs_o[32*i +: 32] = rw_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_q <= 1'b0;
         aw_held_q  <= 1'b0;
         aw_idx_q   <= '0;
         w_held_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= '0;
         for (int unsigned i = 0; i < NumRw; i++) begin
            rw_q[i] <= '0;
         end
      end else begin
         ready_en_q <= 1'b1;
         aw_held_q  <= aw_held_d;
         aw_idx_q   <= aw_idx_d;
         w_held_q   <= w_held_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rw_q       <= rw_d;
      end
   end

endmodule

// File: tb/tb_dataplane_axil_regs.sv
// Self-checking bench for dataplane_axil_regs: vector table, directed corner
// sequences and randomized traffic against a register-array reference model.
module tb_dataplane_axil_regs;

   localparam int unsigned ADDR_W   = 8;
   localparam int unsigned NUM_REGS = 8;
   localparam logic [31:0] VERSION  = 32'h0001_0000;

   logic                   clk;
   logic                   rst_n;
   logic [32*NUM_REGS-1:0] regs;

   dataplane_axil_regs_if #(.ADDR_W(ADDR_W)) axil ();

   dataplane_axil_regs #(
      .ADDR_W  (ADDR_W),
      .NUM_REGS(NUM_REGS),
      .VERSION (VERSION)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .axil  (axil),
      .regs_o(regs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] model [NUM_REGS];

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          aw_dly;
      int          w_dly;
      int          rdly;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      model[0] = VERSION;
      for (int i = 1; i < NUM_REGS; i++) model[i] = '0;
   endfunction

   function automatic bit idx_ok(input logic [7:0] addr);
      int idx = int'(addr >> 2);
      return (idx != 0) && (idx < NUM_REGS);
   endfunction

   function automatic void model_write(input logic [7:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb);
      logic [31:0] mask;
      int idx = int'(addr >> 2);
      if (!idx_ok(addr)) return;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      model[idx] = (model[idx] & ~mask) | (data & mask);
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] addr);
      int idx = int'(addr >> 2);
      if (idx == 0) return VERSION;
      if (idx < NUM_REGS) return model[idx];
      return 32'h0;
   endfunction

   task automatic check_regs(input string name);
      for (int i = 0; i < NUM_REGS; i++) chk(name, regs[32*i +: 32], model[i]);
   endtask

   task automatic bus_idle();
      axil.AWADDR = '0; axil.AWPROT = '0; axil.AWVALID = 1'b0;
      axil.WDATA = '0; axil.WSTRB = '0; axil.WVALID = 1'b0; axil.BREADY = 1'b0;
      axil.ARADDR = '0; axil.ARPROT = '0; axil.ARVALID = 1'b0; axil.RREADY = 1'b0;
   endtask

   // Called #1 after a rising edge; returns at the same phase.
   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            output logic [1:0] resp);
      int n;
      fork
         begin
            int m = 0;
            repeat (aw_dly) @(posedge clk);
            if (aw_dly > 0) #1;
            axil.AWADDR = addr; axil.AWPROT = 3'($urandom); axil.AWVALID = 1'b1;
            while (!axil.AWREADY && m < 50) begin @(posedge clk); #1; m++; end
            chk("awready_wait", {31'b0, axil.AWREADY}, 32'd1);
            @(posedge clk); #1;
            axil.AWVALID = 1'b0;
         end
         begin
            int m = 0;
            repeat (w_dly) @(posedge clk);
            if (w_dly > 0) #1;
            axil.WDATA = data; axil.WSTRB = strb; axil.WVALID = 1'b1;
            while (!axil.WREADY && m < 50) begin @(posedge clk); #1; m++; end
            chk("wready_wait", {31'b0, axil.WREADY}, 32'd1);
            @(posedge clk); #1;
            axil.WVALID = 1'b0;
         end
      join
      n = 0;
      axil.BREADY = 1'b1;
      while (!axil.BVALID && n < 50) begin @(posedge clk); #1; n++; end
      chk("bvalid_wait", {31'b0, axil.BVALID}, 32'd1);
      resp = axil.BRESP;
      @(posedge clk); #1;
      axil.BREADY = 1'b0;
      chk("bvalid_drop", {31'b0, axil.BVALID}, 32'd0);
   endtask

   task automatic axi_read(input logic [7:0] addr, input int rdly,
                           output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      axil.ARADDR = addr; axil.ARPROT = 3'($urandom); axil.ARVALID = 1'b1;
      while (!axil.ARREADY && n < 50) begin @(posedge clk); #1; n++; end
      chk("arready_wait", {31'b0, axil.ARREADY}, 32'd1);
      @(posedge clk); #1;
      axil.ARVALID = 1'b0;
      chk("rvalid_after_ar", {31'b0, axil.RVALID}, 32'd1);
      data = axil.RDATA;
      resp = axil.RRESP;
      for (int k = 0; k < rdly; k++) begin
         @(posedge clk); #1;
         chk("rdata_hold", axil.RDATA, data);
      end
      axil.RREADY = 1'b1;
      @(posedge clk); #1;
      axil.RREADY = 1'b0;
      chk("rvalid_drop", {31'b0, axil.RVALID}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] rd, old;
      logic [7:0]  addr;

      tbl[0]  = '{1'b0, 8'h00, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'h0001_0000};
      tbl[1]  = '{1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0};
      tbl[2]  = '{1'b0, 8'h04, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF};
      tbl[3]  = '{1'b1, 8'h04, 32'h1234_5678, 4'h5, 3, 0, 0, 2'b00, 32'h0};
      tbl[4]  = '{1'b0, 8'h04, 32'h0,         4'h0, 0, 0, 2, 2'b00, 32'hDE34_BE78};
      tbl[5]  = '{1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b10, 32'h0};
      tbl[6]  = '{1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 2'b10, 32'h0};
      tbl[7]  = '{1'b0, 8'h20, 32'h0,         4'h0, 0, 0, 0, 2'b10, 32'h0};
      tbl[8]  = '{1'b0, 8'h00, 32'h0,         4'h0, 0, 0, 1, 2'b00, 32'h0001_0000};
      tbl[9]  = '{1'b1, 8'h0B, 32'hA5A5_A5A5, 4'h0, 0, 0, 0, 2'b00, 32'h0};
      tbl[10] = '{1'b0, 8'h08, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'h0};
      tbl[11] = '{1'b1, 8'h1C, 32'hCAFE_F00D, 4'hF, 0, 2, 0, 2'b00, 32'h0};
      tbl[12] = '{1'b0, 8'h1F, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'hCAFE_F00D};
      tbl[13] = '{1'b0, 8'h3C, 32'h0,         4'h0, 0, 0, 0, 2'b10, 32'h0};
      tbl[14] = '{1'b0, 8'h05, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'hDE34_BE78};

      bus_idle();
      model_reset();
      rst_n = 1'b0;

      // Reset and READY gating around the first post-reset edge.
      #2;
      chk("awready_in_reset", {31'b0, axil.AWREADY}, 32'd0);
      chk("arready_in_reset", {31'b0, axil.ARREADY}, 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      chk("ready_before_first_edge",
          {29'b0, axil.AWREADY, axil.WREADY, axil.ARREADY}, 32'd0);
      chk("reset_resp", {26'b0, axil.BVALID, axil.RVALID, axil.BRESP, axil.RRESP}, 32'd0);
      chk("reset_rdata", axil.RDATA, 32'd0);
      check_regs("reset_regs");
      @(posedge clk); #1;
      chk("ready_after_first_edge",
          {29'b0, axil.AWREADY, axil.WREADY, axil.ARREADY}, 32'd7);

      // Vector table.
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].wr) begin
            axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].aw_dly, tbl[i].w_dly, resp);
            model_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            chk($sformatf("tbl%0d_bresp", i), {30'b0, resp}, {30'b0, tbl[i].resp});
         end else begin
            axi_read(tbl[i].addr, tbl[i].rdly, rd, resp);
            chk($sformatf("tbl%0d_rresp", i), {30'b0, resp}, {30'b0, tbl[i].resp});
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
         end
      end
      check_regs("tbl_regs");

      // Same-cycle AW+W: BVALID one edge later; a read on the commit edge sees old data.
      old = model[3];
      axil.AWADDR = 8'h0C; axil.AWVALID = 1'b1;
      axil.WDATA = 32'h1122_3344; axil.WSTRB = 4'hF; axil.WVALID = 1'b1;
      @(posedge clk); #1;
      axil.AWVALID = 1'b0; axil.WVALID = 1'b0;
      chk("bvalid_not_early", {31'b0, axil.BVALID}, 32'd0);
      axil.ARADDR = 8'h0C; axil.ARVALID = 1'b1;
      @(posedge clk); #1;
      axil.ARVALID = 1'b0;
      chk("bvalid_latency", {31'b0, axil.BVALID}, 32'd1);
      chk("bresp_latency", {30'b0, axil.BRESP}, 32'd0);
      chk("read_on_commit_precommit", axil.RDATA, old);
      model_write(8'h0C, 32'h1122_3344, 4'hF);
      check_regs("commit_regs");
      axil.BREADY = 1'b1; axil.RREADY = 1'b1;
      @(posedge clk); #1;
      axil.BREADY = 1'b0; axil.RREADY = 1'b0;
      chk("both_resp_done", {30'b0, axil.BVALID, axil.RVALID}, 32'd0);

      // BREADY stalled: response stable and no new write accepted until B completes.
      axil.AWADDR = 8'h04; axil.AWVALID = 1'b1;
      axil.WDATA = 32'h0BAD_F00D; axil.WSTRB = 4'hF; axil.WVALID = 1'b1;
      @(posedge clk); #1;
      axil.AWADDR = 8'h08; axil.WDATA = 32'h7777_8888; axil.WSTRB = 4'h3;
      model_write(8'h04, 32'h0BAD_F00D, 4'hF);
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         chk("bstall_bvalid_bresp", {29'b0, axil.BVALID, axil.BRESP}, 32'd4);
         chk("bstall_readies", {30'b0, axil.AWREADY, axil.WREADY}, 32'd0);
         @(posedge clk); #1;
      end
      check_regs("bstall_regs");
      axil.BREADY = 1'b1;
      @(posedge clk); #1;
      axil.BREADY = 1'b0;
      chk("bstall_released", {29'b0, axil.BVALID, axil.AWREADY, axil.WREADY}, 32'd3);
      @(posedge clk); #1;
      axil.AWVALID = 1'b0; axil.WVALID = 1'b0;
      model_write(8'h08, 32'h7777_8888, 4'h3);
      @(posedge clk); #1;
      chk("second_write_bvalid", {31'b0, axil.BVALID}, 32'd1);
      axil.BREADY = 1'b1;
      @(posedge clk); #1;
      axil.BREADY = 1'b0;
      check_regs("second_write_regs");

      // Read stalled while a write to the same register completes, then reset mid-read.
      old = model[2];
      axil.ARADDR = 8'h08; axil.ARVALID = 1'b1;
      @(posedge clk); #1;
      axil.ARVALID = 1'b0;
      axi_write(8'h08, 32'h5A5A_C3C3, 4'hF, 0, 1, resp);
      model_write(8'h08, 32'h5A5A_C3C3, 4'hF);
      chk("rstall_write_resp", {30'b0, resp}, 32'd0);
      chk("rstall_rvalid", {31'b0, axil.RVALID}, 32'd1);
      chk("rstall_rdata", axil.RDATA, old);
      check_regs("rstall_regs");
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_rvalid", {31'b0, axil.RVALID}, 32'd0);
      chk("midreset_reg2", regs[64 +: 32], 32'd0);
      model_reset();
      check_regs("midreset_regs");
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Randomized traffic against the reference model.
      for (int i = 0; i < 120; i++) begin
         addr = {2'($urandom_range(0, NUM_REGS + 3) >> 4),
                 4'($urandom_range(0, NUM_REGS + 3)), 2'($urandom)};
         if ($urandom_range(0, 1) == 1) begin
            logic [31:0] d = $urandom;
            logic [3:0]  s = 4'($urandom);
            axi_write(addr, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp);
            chk("rand_bresp", {30'b0, resp}, idx_ok(addr) ? 32'd0 : 32'd2);
            model_write(addr, d, s);
         end else begin
            axi_read(addr, $urandom_range(0, 2), rd, resp);
            chk("rand_rresp", {30'b0, resp},
                (idx_ok(addr) || (addr >> 2) == 0) ? 32'd0 : 32'd2);
            chk("rand_rdata", rd, model_read(addr));
         end
      end
      check_regs("rand_regs");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dataplane_axil_regs.md
Name: dataplane_axil_regs

Overview:
AXI4-Lite slave register bank inside dataplane_top; first stage downstream of the PS/testbench AXI4-Lite master.
Terminates AW/W/B/AR/R channels and decodes word addresses into a read-only version register plus NUM_REGS-1 read/write control registers.
The RW registers are exported flat to the dataplane datapath.
Responses are OKAY or SLVERR; no interconnect logic.

Parameters:
ADDR_W, 8, AXI address width in bits; word index = ADDR[ADDR_W-1:2].
NUM_REGS, 8, total registers; index 0 = VERSION (RO), indices 1..NUM_REGS-1 RW; 2 <= NUM_REGS <= 2^(ADDR_W-2).
VERSION, 32'h0001_0000, constant returned at index 0.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
AWADDR  in  ADDR_W  write address.
AWPROT  in  3  ignored.
AWVALID  in  1  write address valid.
AWREADY  out  1  write address ready.
WDATA  in  32  write data.
WSTRB  in  4  byte enables.
WVALID  in  1  write data valid.
WREADY  out  1  write data ready.
BREADY  in  1  master accepts response.
BVALID  out  1  write response valid.
BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
ARADDR  in  ADDR_W  read address.
ARPROT  in  3  ignored.
ARVALID  in  1  read address valid.
ARREADY  out  1  read address ready.
RREADY  in  1  master accepts read data.
RVALID  out  1  read data valid.
RDATA  out  32  read data.
RRESP  out  2  read response.
regs_o  out  32*NUM_REGS  flat register image; slice i = register i; slice 0 = VERSION.

Behaviour:
- Reset: all flops clear asynchronously. AWREADY=WREADY=ARREADY=BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, RW registers=0.
- A ready_en flop is set on the first clk edge with rst_n=1. All READY outputs are gated by ready_en, so they are 0 during reset and for that first edge.
- Write path (AW and W are independent):
  - aw_held latches AWADDR on AWVALID&&AWREADY; w_held latches WDATA/WSTRB on WVALID&&WREADY.
  - AWREADY = ready_en && !aw_held && !BVALID. WREADY = ready_en && !w_held && !BVALID.
  - AW and W may arrive in the same cycle or in either order, any gap.
  - Commit on the edge after both are held: for each WSTRB[b]=1, write byte b of the target register. Clear aw_held and w_held, set BVALID.
  - Latency: same-cycle AW+W handshake at edge N -> commit and BVALID=1 after edge N+1.
  - BVALID and BRESP hold until BVALID&&BREADY; BVALID drops on that edge.
  - Next AW/W is accepted only after B completes: one outstanding write.
- Write decode:
  - index 0 -> SLVERR, no update.
  - index >= NUM_REGS -> SLVERR, no update.
  - otherwise OKAY. WSTRB=0 -> OKAY, no change.
  - Low address bits [1:0] are ignored.
- Read path:
  - ARREADY = ready_en && !RVALID.
  - On AR handshake at edge N: RVALID=1, RDATA and RRESP registered after edge N.
  - Index 0 returns VERSION, OKAY. Valid RW index returns register value, OKAY. Out-of-range index returns RDATA=0, SLVERR.
  - RVALID, RDATA and RRESP hold until RVALID&&RREADY. One outstanding read.
- Read and write paths run concurrently. A read sampled on the same edge as a write commit to the same register returns the pre-commit value.
- rst_n asserted mid-transaction: everything clears immediately; pending responses are dropped.
- regs_o is driven directly from register flops, so it updates on the commit edge.

Test Plan:
- Reset release -> READYs 0 during reset and first edge, then AWREADY/WREADY/ARREADY=1; read index 0 -> RDATA=32'h0001_0000, RRESP=00.
- Same-cycle AW=0x04, W=0xDEADBEEF, WSTRB=4'hF, BREADY=1 -> BVALID one cycle after handshake, BRESP=00; regs_o[63:32]=0xDEADBEEF; read 0x04 returns 0xDEADBEEF.
- W first (0x12345678, WSTRB=4'b0101), AW=0x04 three cycles later -> reg1 = 0xDE34BE78, OKAY.
- BREADY held 0 for 5 cycles after write -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout, second write accepted only after B handshake.
- Write 0x00 and write 0x20 (NUM_REGS=8) -> BRESP=10, registers unchanged; read 0x20 -> RDATA=0, RRESP=10.
- RREADY=0 for 4 cycles, concurrent write to reg2 -> RDATA stable, write completes independently; mid-read rst_n=0 -> RVALID=0 immediately, reg2=0.
